vehicle_check_sequencer: RTL

VEHICLE_CHECK_SEQUENCER -- requirements
Module: vehicle_check_sequencer

---
 rtl/vehicle_check_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vehicle_check_sequencer.sv
// Vehicle start check sequencer: walks six sensor checks (fuel, door, seat belt,
// brakes, blood pressure, stress level), one request/response handshake each,
// then enables vehicle start or latches a fault naming the failing check.
// Optional feature macro: CHECK_RETRY_EN (re-issue a failed check up to
// RETRY_MAX times before faulting). Without it, any failure faults at once.
module vehicle_check_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RETRY_MAX      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       abort,
  input  logic       check_ack,
  input  logic       check_pass,
  output logic       check_req,
  output logic [3:0] check_id,
  output logic [4:0] light,
  output logic [3:0] state,
  output logic       flag,
  output logic       fault,
  output logic [3:0] fault_code
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_REQ   = 4'd1,
    ST_WAIT  = 4'd2,
    ST_DONE  = 4'd3,
    ST_FAULT = 4'd4
  } state_t;

  localparam logic [3:0] FirstCheck  = 4'd1;
  localparam logic [3:0] LastCheck   = 4'd6;
  localparam logic [4:0] DoneLight   = 5'b00111;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] check_id_q, check_id_d;
  logic       check_req_q, check_req_d;
  logic [4:0] light_q, light_d;
  logic       flag_q, flag_d;
  logic       fault_q, fault_d;
  logic [3:0] fault_code_q, fault_code_d;
  logic [7:0] timer_q, timer_d;
  logic       failed;

`ifdef CHECK_RETRY_EN
  localparam logic [1:0] RetryLimit = 2'(RETRY_MAX);
  logic [1:0] retry_q, retry_d;
`endif

  // Next-state and next-output computation for the check sequence; abort overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    check_id_d   = check_id_q;
    check_req_d  = 1'b0;
    light_d      = light_q;
    flag_d       = flag_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    timer_d      = timer_q;
    failed       = 1'b0;
`ifdef CHECK_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d     = ST_REQ;
          check_id_d  = FirstCheck;
          check_req_d = 1'b1;
`ifdef CHECK_RETRY_EN
          retry_d     = 2'd0;
`endif
        end
      end
      ST_REQ: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (check_ack) begin
          if (check_pass) begin
            light_d = {1'b0, check_id_q};
`ifdef CHECK_RETRY_EN
            retry_d = 2'd0;
`endif
            if (check_id_q == LastCheck) begin
              state_d = ST_DONE;
            end else begin
              check_id_d  = check_id_q + 4'd1;
              check_req_d = 1'b1;
              state_d     = ST_REQ;
            end
          end else begin
            failed = 1'b1;
          end
        end else if (timer_q == TimeoutLast) begin
          failed = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end

        if (failed) begin
`ifdef CHECK_RETRY_EN
          if (retry_q < RetryLimit) begin
            retry_d     = retry_q + 2'd1;
            check_req_d = 1'b1;
            state_d     = ST_REQ;
          end else begin
            state_d      = ST_FAULT;
            fault_d      = 1'b1;
            fault_code_d = check_id_q;
            light_d      = {1'b1, check_id_q};
            flag_d       = 1'b0;
          end
`else
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = check_id_q;
          light_d      = {1'b1, check_id_q};
          flag_d       = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        flag_d  = 1'b1;
        light_d = DoneLight;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      check_id_d   = 4'd0;
      check_req_d  = 1'b0;
      light_d      = 5'd0;
      flag_d       = 1'b0;
      fault_d      = 1'b0;
      fault_code_d = 4'd0;
      timer_d      = 8'd0;
`ifdef CHECK_RETRY_EN
      retry_d      = 2'd0;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      check_id_q   <= 4'd0;
      check_req_q  <= 1'b0;
      light_q      <= 5'd0;
      flag_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 4'd0;
      timer_q      <= 8'd0;
`ifdef CHECK_RETRY_EN
      retry_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      check_id_q   <= check_id_d;
      check_req_q  <= check_req_d;
      light_q      <= light_d;
      flag_q       <= flag_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      timer_q      <= timer_d;
`ifdef CHECK_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign state      = state_q;
  assign check_id   = check_id_q;
  assign check_req  = check_req_q;
  assign light      = light_q;
  assign flag       = flag_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
